alu_sched_2_16: RTL and testbench

Two-requester scheduler that shares one `alu_2_14` datapath between two independent operation sources. Requests arrive on per-requester valid/ready channels; a round-robin arbiter grants one per cycle, the ALU result is registered into a single output slot tagged with the requester ID, and the slot is held until the consumer accepts it. The block sits between the instruction/operand sources and the result writeback.

---
 rtl/alu_sched_2_16_pkg.sv | 18 +
 rtl/alu_sched_2_16_if.sv | 35 +++
 rtl/alu_sched_2_16_alu.sv | 32 +++
 rtl/alu_sched_2_16.sv | 108 ++++++++++
 tb/tb_alu_sched_2_16.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_sched_2_16_pkg.sv
// Shared opcodes, slot state and requester-ID type for the two-requester ALU scheduler.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;

  localparam int unsigned ID_W = 1;
  typedef logic [ID_W-1:0] req_id_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/alu_sched_2_16_if.sv
// Request/result channel bundle between the operation sources, the scheduler and writeback.
interface alu_sched_2_16_if #(
  parameter int unsigned WIDTH = 4
) ();

  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2:0]         req_control0;
  logic [2:0]         req_control1;
  logic [WIDTH-1:0]   req_a0;
  logic [WIDTH-1:0]   req_b0;
  logic [WIDTH-1:0]   req_a1;
  logic [WIDTH-1:0]   req_b1;
  logic               res_valid;
  logic               res_ready;
  logic [2*WIDTH-1:0] res_data;
  logic               res_id;

  // Sources and consumer side
  modport master (
    output req_valid, req_control0, req_control1,
    output req_a0, req_b0, req_a1, req_b1,
    output res_ready,
    input  req_ready, res_valid, res_data, res_id
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_control0, req_control1,
    input  req_a0, req_b0, req_a1, req_b1,
    input  res_ready,
    output req_ready, res_valid, res_data, res_id
  );

endinterface

// File: rtl/alu_sched_2_16_alu.sv
// Combinational ALU datapath: zero-extended operands, results mod 2^(2*WIDTH).
module alu_2_14
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [2:0]         control,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] y
);

  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;

  assign ext_a = {{WIDTH{1'b0}}, a};
  assign ext_b = {{WIDTH{1'b0}}, b};

  // Opcode decode; unused opcodes yield zero
  always_comb begin
    y = '0;
    case (control)
      OP_ADD:  y = ext_a + ext_b;
      OP_SUB:  y = ext_a - ext_b;
      OP_MUL:  y = ext_a * ext_b;
      OP_AND:  y = ext_a & ext_b;
      OP_OR:   y = ext_a | ext_b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_sched_2_16.sv
// Round-robin scheduler sharing one ALU between two requesters, with a single
// registered result slot and a completed-operation counter.
module alu_sched_2_16
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  alu_sched_2_16_if.slave    bus,
  output logic [CNT_W-1:0]   op_count
);

  slot_state_e        state_q, state_d;
  req_id_t            last_grant_q, last_grant_d;
  logic [2*WIDTH-1:0] res_data_q, res_data_d;
  req_id_t            res_id_q, res_id_d;
  logic [CNT_W-1:0]   op_count_q, op_count_d;

  logic               slot_free;
  logic               gnt_valid;
  req_id_t            gnt_id;
  logic               accept;
  logic [1:0]         req_ready;
  logic [2:0]         alu_control;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [2*WIDTH-1:0] alu_y;

  // Arbitration: single valid wins; on a tie the requester not granted last wins
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    case (bus.req_valid)
      2'b01: begin gnt_valid = 1'b1; gnt_id = 1'b0; end
      2'b10: begin gnt_valid = 1'b1; gnt_id = 1'b1; end
      2'b11: begin gnt_valid = 1'b1; gnt_id = ~last_grant_q; end
      default: begin gnt_valid = 1'b0; gnt_id = '0; end
    endcase
    slot_free = (state_q == EMPTY) || bus.res_ready;
    accept    = gnt_valid && slot_free && !rst;
    req_ready = '0;
    if (accept) req_ready[gnt_id] = 1'b1;
  end

  // Operand/control mux for the granted requester
  always_comb begin
    alu_control = bus.req_control0;
    alu_a       = bus.req_a0;
    alu_b       = bus.req_b0;
    if (gnt_id == 1'b1) begin
      alu_control = bus.req_control1;
      alu_a       = bus.req_a1;
      alu_b       = bus.req_b1;
    end
  end

  alu_2_14 #(.WIDTH(WIDTH)) u_alu (
    .control (alu_control),
    .a       (alu_a),
    .b       (alu_b),
    .y       (alu_y)
  );

  // Slot FSM, result load, grant history and completion counter next-state
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    res_data_d   = res_data_q;
    res_id_d     = res_id_q;
    op_count_d   = op_count_q;
    if ((state_q == FULL) && bus.res_ready) begin
      op_count_d = op_count_q + CNT_W'(1);
      state_d    = EMPTY;
    end
    if (accept) begin
      state_d      = FULL;
      last_grant_d = gnt_id;
      res_data_d   = alu_y;
      res_id_d     = gnt_id;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      last_grant_q <= 1'b1;
      res_data_q   <= '0;
      res_id_q     <= '0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      res_data_q   <= res_data_d;
      res_id_q     <= res_id_d;
      op_count_q   <= op_count_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.res_valid = (state_q == FULL);
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign op_count      = op_count_q;

endmodule

// File: tb/tb_alu_sched_2_16.sv
// Directed bench for alu_sched_2_16 (counter narrowed to 4 bits to exercise wrap).
module tb_alu_sched_2_16;

  logic       clk;
  logic       rst;
  logic [3:0] op_count;
  int         checks;
  int         fails;

  alu_sched_2_16_if #(.WIDTH(4)) bus ();

  alu_sched_2_16 #(.WIDTH(4), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = 2'b00;
    bus.req_control0 = 3'd0; bus.req_control1 = 3'd0;
    bus.req_a0 = 4'd0; bus.req_b0 = 4'd0; bus.req_a1 = 4'd0; bus.req_b1 = 4'd0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    bus.res_ready = 1'b1;
    tick();
    bus.req_valid = 2'b11;
    #1;
    checks++; if (bus.req_ready !== 2'b00) begin fails++; $display("FAIL rst_req_ready: got %b expected 00", bus.req_ready); end
    tick();
    checks++; if (bus.res_valid !== 1'b0) begin fails++; $display("FAIL rst_res_valid: got %b expected 0", bus.res_valid); end
    checks++; if (bus.res_data !== 8'h00) begin fails++; $display("FAIL rst_res_data: got %h expected 00", bus.res_data); end
    checks++; if (bus.res_id !== 1'b0) begin fails++; $display("FAIL rst_res_id: got %b expected 0", bus.res_id); end
    checks++; if (op_count !== 4'd0) begin fails++; $display("FAIL rst_op_count: got %0d expected 0", op_count); end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_tie();
    logic       eid;
    logic [7:0] edata;
    bus.req_valid = 2'b11;
    bus.req_control0 = 3'd2; bus.req_a0 = 4'd15; bus.req_b0 = 4'd15;
    bus.req_control1 = 3'd1; bus.req_a1 = 4'd2;  bus.req_b1 = 4'd3;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      eid   = (i % 2 == 1);
      edata = eid ? 8'd255 : 8'd225;
      #1;
      checks++; if (bus.req_ready !== (eid ? 2'b10 : 2'b01)) begin fails++; $display("FAIL tie_req_ready[%0d]: got %b expected %b", i, bus.req_ready, eid ? 2'b10 : 2'b01); end
      tick();
      checks++; if (bus.res_valid !== 1'b1) begin fails++; $display("FAIL tie_res_valid[%0d]: got %b expected 1", i, bus.res_valid); end
      checks++; if (bus.res_id !== eid) begin fails++; $display("FAIL tie_res_id[%0d]: got %b expected %b", i, bus.res_id, eid); end
      checks++; if (bus.res_data !== edata) begin fails++; $display("FAIL tie_res_data[%0d]: got %0d expected %0d", i, bus.res_data, edata); end
      checks++; if (op_count !== 4'(i)) begin fails++; $display("FAIL tie_op_count[%0d]: got %0d expected %0d", i, op_count, i); end
    end
    idle();
    tick();
    checks++; if (bus.res_valid !== 1'b0) begin fails++; $display("FAIL tie_drain_valid: got %b expected 0", bus.res_valid); end
    checks++; if (op_count !== 4'd4) begin fails++; $display("FAIL tie_drain_count: got %0d expected 4", op_count); end
  endtask

  task automatic test_single();
    bus.req_valid = 2'b01;
    bus.req_control0 = 3'd0; bus.req_a0 = 4'd3; bus.req_b0 = 4'd5;
    bus.res_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin fails++; $display("FAIL single_req_ready: got %b expected 01", bus.req_ready); end
    tick();
    idle();
    checks++; if (bus.res_valid !== 1'b1) begin fails++; $display("FAIL single_res_valid: got %b expected 1", bus.res_valid); end
    checks++; if (bus.res_data !== 8'd8) begin fails++; $display("FAIL single_res_data: got %0d expected 8", bus.res_data); end
    checks++; if (bus.res_id !== 1'b0) begin fails++; $display("FAIL single_res_id: got %b expected 0", bus.res_id); end
    tick();
    checks++; if (op_count !== 4'd5) begin fails++; $display("FAIL single_op_count: got %0d expected 5", op_count); end
    checks++; if (bus.res_valid !== 1'b0) begin fails++; $display("FAIL single_drain_valid: got %b expected 0", bus.res_valid); end
  endtask

  task automatic test_back_to_back();
    bus.res_ready = 1'b0;
    bus.req_valid = 2'b10;
    bus.req_control1 = 3'd3; bus.req_a1 = 4'hC; bus.req_b1 = 4'hA;
    #1;
    checks++; if (bus.req_ready !== 2'b10) begin fails++; $display("FAIL bp_req_ready_first: got %b expected 10", bus.req_ready); end
    tick();
    bus.req_valid = 2'b01;
    bus.req_control0 = 3'd4; bus.req_a0 = 4'h5; bus.req_b0 = 4'hA;
    bus.req_a1 = 4'h1; bus.req_control1 = 3'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.req_ready !== 2'b00) begin fails++; $display("FAIL bp_req_ready[%0d]: got %b expected 00", i, bus.req_ready); end
      checks++; if (bus.res_data !== 8'h08) begin fails++; $display("FAIL bp_res_data[%0d]: got %h expected 08", i, bus.res_data); end
      checks++; if (bus.res_id !== 1'b1) begin fails++; $display("FAIL bp_res_id[%0d]: got %b expected 1", i, bus.res_id); end
      checks++; if (op_count !== 4'd5) begin fails++; $display("FAIL bp_op_count[%0d]: got %0d expected 5", i, op_count); end
      tick();
    end
    bus.res_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin fails++; $display("FAIL b2b_req_ready: got %b expected 01", bus.req_ready); end
    tick();
    idle();
    checks++; if (bus.res_valid !== 1'b1) begin fails++; $display("FAIL b2b_res_valid: got %b expected 1", bus.res_valid); end
    checks++; if (bus.res_data !== 8'h0F) begin fails++; $display("FAIL b2b_res_data: got %h expected 0f", bus.res_data); end
    checks++; if (bus.res_id !== 1'b0) begin fails++; $display("FAIL b2b_res_id: got %b expected 0", bus.res_id); end
    checks++; if (op_count !== 4'd6) begin fails++; $display("FAIL b2b_op_count: got %0d expected 6", op_count); end
    tick();
    checks++; if (op_count !== 4'd7) begin fails++; $display("FAIL b2b_drain_count: got %0d expected 7", op_count); end
  endtask

  task automatic test_opcodes();
    logic [2:0] ops [8];
    logic [3:0] as  [8];
    logic [3:0] bs  [8];
    logic [7:0] exp [8];
    ops = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    as  = '{4'd15, 4'd0, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
    bs  = '{4'd15, 4'd1, 4'd9, 4'd12, 4'd6, 4'd9, 4'd9, 4'd9};
    exp = '{8'd30, 8'd255, 8'd81, 8'd8, 8'd15, 8'd0, 8'd0, 8'd0};
    bus.res_ready = 1'b1;
    bus.req_valid = 2'b10;
    bus.req_control0 = 3'd0; bus.req_a0 = 4'd7; bus.req_b0 = 4'd7;
    for (int i = 0; i < 8; i++) begin
      bus.req_control1 = ops[i]; bus.req_a1 = as[i]; bus.req_b1 = bs[i];
      tick();
      checks++; if (bus.res_data !== exp[i]) begin fails++; $display("FAIL op%0d_res_data: got %0d expected %0d", ops[i], bus.res_data, exp[i]); end
      checks++; if (bus.res_id !== 1'b1) begin fails++; $display("FAIL op%0d_res_id: got %b expected 1", ops[i], bus.res_id); end
      checks++; if (op_count !== 4'(7 + i)) begin fails++; $display("FAIL op%0d_op_count: got %0d expected %0d", ops[i], op_count, 7 + i); end
    end
    idle();
    tick();
    checks++; if (op_count !== 4'd15) begin fails++; $display("FAIL op_drain_count: got %0d expected 15", op_count); end
  endtask

  task automatic test_reset_mid();
    bus.res_ready = 1'b0;
    bus.req_valid = 2'b01;
    bus.req_control0 = 3'd0; bus.req_a0 = 4'd12; bus.req_b0 = 4'd13;
    tick();
    checks++; if (bus.res_data !== 8'h19) begin fails++; $display("FAIL rmid_loaded: got %h expected 19", bus.res_data); end
    rst = 1'b1;
    bus.res_ready = 1'b1;
    bus.req_valid = 2'b11;
    #1;
    checks++; if (bus.req_ready !== 2'b00) begin fails++; $display("FAIL rmid_req_ready: got %b expected 00", bus.req_ready); end
    tick();
    rst = 1'b0;
    checks++; if (bus.res_valid !== 1'b0) begin fails++; $display("FAIL rmid_res_valid: got %b expected 0", bus.res_valid); end
    checks++; if (bus.res_data !== 8'h00) begin fails++; $display("FAIL rmid_res_data: got %h expected 00", bus.res_data); end
    checks++; if (op_count !== 4'd0) begin fails++; $display("FAIL rmid_op_count: got %0d expected 0", op_count); end
    bus.req_control0 = 3'd0; bus.req_a0 = 4'd1; bus.req_b0 = 4'd1;
    bus.req_control1 = 3'd0; bus.req_a1 = 4'd2; bus.req_b1 = 4'd2;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin fails++; $display("FAIL rmid_tie_ready: got %b expected 01", bus.req_ready); end
    tick();
    idle();
    checks++; if (bus.res_id !== 1'b0) begin fails++; $display("FAIL rmid_tie_id: got %b expected 0", bus.res_id); end
    checks++; if (bus.res_data !== 8'd2) begin fails++; $display("FAIL rmid_tie_data: got %0d expected 2", bus.res_data); end
    tick();
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    bus.res_ready = 1'b1;
    bus.req_valid = 2'b01;
    bus.req_control0 = 3'd0; bus.req_a0 = 4'd1; bus.req_b0 = 4'd0;
    for (int i = 0; i < 16; i++) tick();
    checks++; if (op_count !== 4'd15) begin fails++; $display("FAIL wrap_count_15: got %0d expected 15", op_count); end
    idle();
    tick();
    checks++; if (op_count !== 4'd0) begin fails++; $display("FAIL wrap_count_0: got %0d expected 0", op_count); end
    checks++; if (bus.res_valid !== 1'b0) begin fails++; $display("FAIL wrap_res_valid: got %b expected 0", bus.res_valid); end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst    = 1'b1;
    bus.res_ready = 1'b0;
    idle();
    test_reset();
    test_tie();
    test_single();
    test_back_to_back();
    test_opcodes();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
